// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing a single-port synchronous RAM.
// Define MEM_ARBITER_FIXED_PRIO_EN to make port 0 always win on a simultaneous request.
module mem_arbiter #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 16,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] address,
    output logic [DW-1:0] data_out,
    input  logic [DW-1:0] data_in,
    output logic          wren_n,
    output logic          oen_n
);

    localparam int unsigned CW = 2;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RDWAIT = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]    state, state_nxt;
    logic          sel, sel_nxt;
    logic          we_q, we_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [AW-1:0] address_nxt;
    logic [DW-1:0] data_out_nxt;
    logic          wren_n_nxt, oen_n_nxt;
    logic          m0_ack_nxt, m1_ack_nxt;
    logic [DW-1:0] m0_rdata_nxt, m1_rdata_nxt;
    logic          grant, any_req;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
    logic          last_grant, last_grant_nxt;
`endif

    // Port selection for the IDLE sample
    always_comb begin
        any_req = m0_req | m1_req;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
        grant = ~m0_req;
`else
        if (m0_req && m1_req)
            grant = ~last_grant;
        else
            grant = ~m0_req;
`endif
    end

    // Next-state and next-output logic; strobes default high so every state but ACCESS releases them
    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel;
        we_nxt       = we_q;
        cnt_nxt      = cnt;
        address_nxt  = address;
        data_out_nxt = data_out;
        wren_n_nxt   = 1'b1;
        oen_n_nxt    = 1'b1;
        m0_ack_nxt   = 1'b0;
        m1_ack_nxt   = 1'b0;
        m0_rdata_nxt = m0_rdata;
        m1_rdata_nxt = m1_rdata;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
        last_grant_nxt = last_grant;
`endif
        case (state)
            IDLE: begin
                if (any_req) begin
                    sel_nxt      = grant;
                    we_nxt       = grant ? m1_we : m0_we;
                    address_nxt  = grant ? m1_addr : m0_addr;
                    data_out_nxt = grant ? m1_wdata : m0_wdata;
                    wren_n_nxt   = ~(grant ? m1_we : m0_we);
                    oen_n_nxt    = grant ? m1_we : m0_we;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
                    last_grant_nxt = grant;
`endif
                    state_nxt    = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    m0_ack_nxt = ~sel;
                    m1_ack_nxt = sel;
                    state_nxt  = DONE;
                end else begin
                    cnt_nxt   = CW'(RD_LATENCY - 1);
                    state_nxt = RDWAIT;
                end
            end
            RDWAIT: begin
                if (cnt == '0) begin
                    if (sel) m1_rdata_nxt = data_in;
                    else     m0_rdata_nxt = data_in;
                    m0_ack_nxt = ~sel;
                    m1_ack_nxt = sel;
                    state_nxt  = DONE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 1'b0;
            we_q     <= 1'b0;
            cnt      <= '0;
            address  <= '0;
            data_out <= '0;
            wren_n   <= 1'b1;
            oen_n    <= 1'b1;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            we_q     <= we_nxt;
            cnt      <= cnt_nxt;
            address  <= address_nxt;
            data_out <= data_out_nxt;
            wren_n   <= wren_n_nxt;
            oen_n    <= oen_n_nxt;
            m0_ack   <= m0_ack_nxt;
            m1_ack   <= m1_ack_nxt;
            m0_rdata <= m0_rdata_nxt;
            m1_rdata <= m1_rdata_nxt;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
            last_grant <= last_grant_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-master transaction table, reset/abort and contention sequences.
module tb_mem_arbiter;

    localparam int unsigned RDL = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [15:0] m0_rdata, m1_rdata;
    logic [15:0] address, data_out, data_in;
    logic        wren_n, oen_n;

    logic [15:0] mem [0:65535];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        scramble;
    } vec_t;

    vec_t vecs [10];

    mem_arbiter #(.AW(16), .DW(16), .RD_LATENCY(RDL)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .address(address), .data_out(data_out), .data_in(data_in),
        .wren_n(wren_n), .oen_n(oen_n)
    );

    always #5 clk = ~clk;

    // Synchronous RAM, one cycle read latency
    always @(posedge clk) begin
        if (!wren_n) mem[address] <= data_out;
        if (!oen_n)  data_in <= mem[address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_txn(input vec_t v, input int idx);
        logic [15:0] other_rd;
        int n, strobes, exp_lat;
        bit got;
        other_rd = v.port ? m0_rdata : m1_rdata;
        exp_lat  = v.we ? 2 : 2 + int'(RDL);
        if (!v.port) begin
            m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
        end else begin
            m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
        end
        n = 0; strobes = 0; got = 1'b0;
        while (!got && n < 16) begin
            @(negedge clk);
            n++;
            chk($sformatf("v%0d_overlap", idx), 32'(!wren_n && !oen_n), 32'd0);
            chk($sformatf("v%0d_other_ack", idx), 32'(v.port ? m0_ack : m1_ack), 32'd0);
            if (!wren_n || !oen_n) begin
                strobes++;
                chk($sformatf("v%0d_strobe_cycle", idx), 32'(n), 32'd1);
                chk($sformatf("v%0d_strobe_kind", idx), 32'(wren_n), 32'(!v.we));
                chk($sformatf("v%0d_address", idx), 32'(address), 32'(v.addr));
                if (v.we) chk($sformatf("v%0d_data_out", idx), 32'(data_out), 32'(v.wdata));
            end
            if (v.scramble && n == 1) begin
                if (!v.port) begin m0_addr = ~v.addr; m0_wdata = ~v.wdata; m0_we = ~v.we; end
                else         begin m1_addr = ~v.addr; m1_wdata = ~v.wdata; m1_we = ~v.we; end
            end
            if (v.port ? m1_ack : m0_ack) begin
                got = 1'b1;
                chk($sformatf("v%0d_latency", idx), 32'(n), 32'(exp_lat));
                if (!v.we)
                    chk($sformatf("v%0d_rdata", idx), 32'(v.port ? m1_rdata : m0_rdata), 32'(v.exp_rdata));
                if (!v.port) m0_req = 1'b0; else m1_req = 1'b0;
            end
        end
        if (!got) chk($sformatf("v%0d_ack_timeout", idx), 32'd0, 32'd1);
        chk($sformatf("v%0d_strobe_count", idx), 32'(strobes), 32'd1);
        chk($sformatf("v%0d_other_rdata", idx), 32'(v.port ? m0_rdata : m1_rdata), 32'(other_rd));
        @(negedge clk);
        chk($sformatf("v%0d_ack_pulse", idx), 32'(m0_ack | m1_ack), 32'd0);
    endtask

    initial begin
        logic p, prev0, prev1, m0_off, fin;
        logic [15:0] last_addr;
        int nacks;
        logic exp_order [4];

        vecs[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 16'hFFFF, 16'hA5A5, 16'h0000, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hA5A5, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 16'h0000, 16'h0001, 16'h0000, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 16'h0030, 16'h5555, 16'h0000, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'h5555, 1'b0};

        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_wren_n", 32'(wren_n), 32'd1);
        chk("rst_oen_n", 32'(oen_n), 32'd1);
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
        chk("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("idle_strobes", 32'({wren_n, oen_n}), 32'd3);
        end

        for (int i = 0; i < 10; i++) do_txn(vecs[i], i);

        // Reset during a write strobe takes effect within the cycle
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0040; m0_wdata = 16'h7777;
        @(negedge clk);
        chk("mid_wren_low", 32'(wren_n), 32'd0);
        rst = 1'b1; m0_req = 1'b0;
        #1;
        chk("mid_rst_wren_n", 32'(wren_n), 32'd1);
        chk("mid_rst_address", 32'(address), 32'd0);
        chk("mid_rst_data_out", 32'(data_out), 32'd0);
        chk("mid_rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", 32'({wren_n, oen_n, m0_ack, m1_ack}), 32'hC);
        end

        // Abort an m1 read while it waits for RAM data
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0010;
        @(negedge clk);
        chk("abort_oen_low", 32'(oen_n), 32'd0);
        @(negedge clk);
        rst = 1'b1; m1_req = 1'b0;
        #1;
        chk("abort_oen_n", 32'(oen_n), 32'd1);
        chk("abort_m1_ack", 32'(m1_ack), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_ack", 32'(m1_ack), 32'd0);
            chk("abort_m1_rdata", 32'(m1_rdata), 32'd0);
        end
        do_txn('{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0}, 10);

        // Contention: both masters request continuously from reset
`ifdef MEM_ARBITER_FIXED_PRIO_EN
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0100; m0_wdata = 16'h1111;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0200; m1_wdata = 16'h2222;
        @(negedge clk);
        rst = 1'b0;
        nacks = 0; m0_off = 1'b0; fin = 1'b0; prev0 = 1'b0; prev1 = 1'b0; last_addr = '0;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            chk("cont_overlap", 32'(!wren_n && !oen_n), 32'd0);
            if (!wren_n) last_addr = address;
            if (m0_ack || m1_ack) begin
                chk("cont_both_ack", 32'(m0_ack && m1_ack), 32'd0);
                p = m1_ack;
                chk("cont_addr", 32'(last_addr), p ? 32'h0200 : 32'h0100);
                chk("cont_pulse", 32'(p ? prev1 : prev0), 32'd0);
                if (m0_off) begin
                    chk("cont_after_drop", 32'(p), 32'd1);
                    m1_req = 1'b0;
                    fin = 1'b1;
                end else begin
                    if (nacks < 4) chk($sformatf("cont_order%0d", nacks), 32'(p), 32'(exp_order[nacks]));
                    nacks++;
                    if (nacks >= 4 && !p) begin
                        m0_req = 1'b0;
                        m0_off = 1'b1;
                    end
                end
            end
            prev0 = m0_ack;
            prev1 = m1_ack;
        end
        if (!fin) chk("cont_timeout", 32'd0, 32'd1);
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
